// File: rtl/cache_ctrl_fsm.sv
// Request sequencer for a direct-mapped, one-word-line, write-back/write-allocate cache.
// Owns the tag/valid/dirty/data arrays, a single-outstanding RAM port, flush, and hit/miss counters.
module cache_ctrl_fsm #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_done,
    output logic [DATA_W-1:0]        cpu_rdata,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [INDEX_W+TAG_W-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt,
    output logic [2:0]               dbg_state
);
    localparam int AW    = INDEX_W + TAG_W;
    localparam int LINES = 1 << INDEX_W;

    // Handshake: cpu_req/flush are taken on a rising edge only while cpu_ready=1;
    // mem_req stays high until the edge that samples mem_ack, then drops.
    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB, REFILL, RESP, FL_SCAN, FL_WB, FL_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 req_we_q, req_we_d;
    logic [AW-1:0]        req_addr_q, req_addr_d;
    logic [DATA_W-1:0]    req_wdata_q, req_wdata_d;
    logic [INDEX_W-1:0]   fl_idx_q, fl_idx_d;
    logic                 cpu_ready_q, cpu_ready_d;
    logic                 cpu_done_q, cpu_done_d;
    logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic                 flush_done_q, flush_done_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

    logic [LINES-1:0]     valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [DATA_W-1:0]    data_mem [LINES];

    logic [INDEX_W-1:0]   req_idx, cur_idx;
    logic [TAG_W-1:0]     req_tag, cur_tag;
    logic [DATA_W-1:0]    cur_data;
    logic                 cur_valid, cur_dirty, hit;
    logic                 line_wr, dirty_wr, dirty_val;
    logic [DATA_W-1:0]    line_data;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[31:AW];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign req_idx   = req_addr_q[INDEX_W-1:0];
    assign req_tag   = req_addr_q[AW-1:INDEX_W];
    assign cur_idx   = (state_q == FL_SCAN || state_q == FL_WB) ? fl_idx_q : req_idx;
    assign cur_tag   = tag_mem[cur_idx];
    assign cur_data  = data_mem[cur_idx];
    assign cur_valid = valid_q[cur_idx];
    assign cur_dirty = dirty_q[cur_idx];
    assign hit       = cur_valid && (cur_tag == req_tag);

    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        fl_idx_d     = fl_idx_q;
        cpu_done_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        flush_done_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        line_wr      = 1'b0;
        line_data    = req_wdata_q;
        dirty_wr     = 1'b0;
        dirty_val    = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    fl_idx_d = '0;
                    state_d  = FL_SCAN;
                end else if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr[AW-1:0];
                    req_wdata_d = cpu_wdata;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    if (req_we_q) begin
                        line_wr   = 1'b1;
                        dirty_wr  = 1'b1;
                        dirty_val = 1'b1;
                    end else begin
                        cpu_rdata_d = cur_data;
                    end
                    state_d = RESP;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    if (cur_valid && cur_dirty) begin
                        state_d = WB;
                    end else if (req_we_q) begin
                        line_wr   = 1'b1;
                        dirty_wr  = 1'b1;
                        dirty_val = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            // Each RAM state issues in its first cycle, so mem_req always rises fresh per transaction.
            WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cur_tag, req_idx};
                    mem_wdata_d = cur_data;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (req_we_q) begin
                        line_wr   = 1'b1;
                        dirty_wr  = 1'b1;
                        dirty_val = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = req_addr_q;
                end else if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    line_wr     = 1'b1;
                    line_data   = mem_rdata;
                    dirty_wr    = 1'b1;
                    dirty_val   = 1'b0;
                    cpu_rdata_d = mem_rdata;
                    state_d     = RESP;
                end
            end
            RESP: begin
                cpu_done_d = 1'b1;
                state_d    = IDLE;
            end
            FL_SCAN: begin
                if (cur_valid && cur_dirty) begin
                    state_d = FL_WB;
                end else if (&fl_idx_q) begin
                    state_d = FL_DONE;
                end else begin
                    fl_idx_d = fl_idx_q + 1'b1;
                end
            end
            FL_WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cur_tag, fl_idx_q};
                    mem_wdata_d = cur_data;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dirty_wr  = 1'b1;
                    dirty_val = 1'b0;
                    if (&fl_idx_q) begin
                        state_d = FL_DONE;
                    end else begin
                        fl_idx_d = fl_idx_q + 1'b1;
                        state_d  = FL_SCAN;
                    end
                end
            end
            FL_DONE: begin
                flush_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cpu_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            fl_idx_q     <= '0;
            cpu_ready_q  <= 1'b1;
            cpu_done_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            fl_idx_q     <= fl_idx_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_done_q   <= cpu_done_d;
            cpu_rdata_q  <= cpu_rdata_d;
            flush_done_q <= flush_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            if (line_wr)  valid_q[cur_idx] <= 1'b1;
            if (dirty_wr) dirty_q[cur_idx] <= dirty_val;
        end
    end

    // Tag and data storage carry no reset; valid_q gates every use.
    always_ff @(posedge clk) begin
        if (line_wr) begin
            tag_mem[cur_idx]  <= req_tag;
            data_mem[cur_idx] <= line_data;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_done   = cpu_done_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign flush_done = flush_done_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: vector table for request traffic plus hand sequences
// for flush, flush/request priority and reset during a refill.
module tb_cache_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, flush;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ready, cpu_done, flush_done;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] hit_cnt, miss_cnt;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    cache_ctrl_fsm dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
    );

    // RAM model: ack three cycles after mem_req rises; mem[a] = a + 0x1000 until written.
    logic [31:0] ram [4096];
    logic        ram_init = 1'b0;
    logic        model_ack = 1'b0;
    logic        extra_ack;
    int          age = 0;
    logic [44:0] obs_q[$];
    logic [44:0] exp_q[$];
    int          rd_ptr = 0;
    int          fd_cnt = 0;

    assign mem_ack = model_ack | extra_ack;

    always @(negedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < 4096; a++) ram[a] = a + 32'h1000;
            ram_init = 1'b1;
            mem_rdata = '0;
        end
        if (rst || !mem_req) begin
            age = 0;
            model_ack = 1'b0;
        end else begin
            age++;
            if (age == 3) begin
                obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
                if (mem_we) ram[mem_addr] = mem_wdata;
                mem_rdata = ram[mem_addr];
                model_ack = 1'b1;
            end else begin
                model_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) if (flush_done) fd_cnt++;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [44:0] tx(input logic we, input logic [11:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic check_txns(input string tag);
        int n_new;
        n_new = obs_q.size() - rd_ptr;
        chk($sformatf("%s txn count", tag), n_new, exp_q.size());
        foreach (exp_q[i]) begin
            if (rd_ptr + i < obs_q.size())
                chk($sformatf("%s txn %0d", tag, i), obs_q[rd_ptr + i], exp_q[i]);
        end
        rd_ptr = obs_q.size();
        exp_q.delete();
    endtask

    // Leaves the bench at the negedge where cpu_done is visible; lat counts edges after accept.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat);
        int guard;
        guard = 0;
        while (!cpu_ready && guard < 100) begin @(negedge clk); guard++; end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(negedge clk);
        cpu_req = 1'b0;
        lat = 0;
        while (!cpu_done && lat < 200) begin @(negedge clk); lat++; end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_hit;
        int          exp_miss;
        int          n_txn;
        logic [44:0] t0;
        logic [44:0] t1;
    } vec_t;

    vec_t vecs[13];

    task automatic run_vec(input int i);
        int lat;
        do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
        chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
        chk($sformatf("v%0d rdata", i), cpu_rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d hit_cnt", i), hit_cnt, vecs[i].exp_hit);
        chk($sformatf("v%0d miss_cnt", i), miss_cnt, vecs[i].exp_miss);
        if (vecs[i].n_txn > 0) exp_q.push_back(vecs[i].t0);
        if (vecs[i].n_txn > 1) exp_q.push_back(vecs[i].t1);
        check_txns($sformatf("v%0d", i));
        @(negedge clk);
        chk($sformatf("v%0d done pulse", i), cpu_done, 1'b0);
    endtask

    task automatic do_flush(input string tag);
        int guard;
        int fd0;
        fd0 = fd_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        guard = 0;
        while (!flush_done && guard < 2000) begin @(negedge clk); guard++; end
        chk($sformatf("%s flush_done seen", tag), flush_done, 1'b1);
        repeat (3) @(negedge clk);
        chk($sformatf("%s flush_done pulses", tag), fd_cnt - fd0, 1);
        check_txns(tag);
    endtask

    initial begin
        int lat;
        int guard;
        int cnt;

        vecs[0]  = '{1'b0, 32'h000, 32'h0,    32'h1000, 6,  0, 1, 1, tx(0, 12'h000, 0), 45'h0};
        vecs[1]  = '{1'b1, 32'h000, 32'h38C0, 32'h1000, 2,  1, 1, 0, 45'h0, 45'h0};
        vecs[2]  = '{1'b0, 32'h000, 32'h0,    32'h38C0, 2,  2, 1, 0, 45'h0, 45'h0};
        vecs[3]  = '{1'b1, 32'hBDC, 32'h2B1,  32'h38C0, 2,  2, 2, 0, 45'h0, 45'h0};
        vecs[4]  = '{1'b1, 32'hA5C, 32'h1A2,  32'h38C0, 6,  2, 3, 1, tx(1, 12'hBDC, 32'h2B1), 45'h0};
        vecs[5]  = '{1'b0, 32'hBDC, 32'h0,    32'h2B1,  10, 2, 4, 2,
                     tx(1, 12'hA5C, 32'h1A2), tx(0, 12'hBDC, 0)};
        vecs[6]  = '{1'b0, 32'h040, 32'h0,    32'h1040, 10, 2, 5, 2,
                     tx(1, 12'h000, 32'h38C0), tx(0, 12'h040, 0)};
        vecs[7]  = '{1'b1, 32'h011, 32'h55AA, 32'h1040, 2,  2, 6, 0, 45'h0, 45'h0};
        vecs[8]  = '{1'b1, 32'h5DC, 32'h777,  32'h1040, 2,  2, 7, 0, 45'h0, 45'h0};
        vecs[9]  = '{1'b0, 32'h5DC, 32'h0,    32'h777,  2,  3, 7, 0, 45'h0, 45'h0};
        vecs[10] = '{1'b0, 32'hFFFF_F5DC, 32'h0, 32'h777, 2, 4, 7, 0, 45'h0, 45'h0};
        vecs[11] = '{1'b0, 32'h011, 32'h0,    32'h55AA, 2,  5, 7, 0, 45'h0, 45'h0};
        vecs[12] = '{1'b0, 32'h051, 32'h0,    32'h1051, 6,  5, 8, 1, tx(0, 12'h051, 0), 45'h0};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        flush = 1'b0; extra_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset cpu_ready", cpu_ready, 1'b1);
        chk("reset cpu_done", cpu_done, 1'b0);
        chk("reset flush_done", flush_done, 1'b0);
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset mem_addr", mem_addr, 12'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset hit_cnt", hit_cnt, 16'h0);
        chk("reset miss_cnt", miss_cnt, 16'h0);
        chk("reset state", dbg_state, 3'd0);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Dirty lines at idx 17 (0x011) and idx 28 (0x5DC); idx 17 is written back first.
        exp_q.push_back(tx(1, 12'h011, 32'h55AA));
        exp_q.push_back(tx(1, 12'h5DC, 32'h777));
        do_flush("flush1");
        chk("flush keeps hit_cnt", hit_cnt, 16'd4);
        chk("flush keeps miss_cnt", miss_cnt, 16'd7);
        do_flush("flush2");

        for (int i = 11; i < 13; i++) run_vec(i);

        // flush and cpu_req together: flush runs first, request taken right after flush_done.
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5DC; cpu_wdata = '0;
        @(negedge clk);
        flush = 1'b0;
        guard = 0;
        while (!flush_done && guard < 2000) begin @(negedge clk); guard++; end
        chk("prio flush_done seen", flush_done, 1'b1);
        chk("prio no early done", cpu_done, 1'b0);
        chk("prio hit_cnt held", hit_cnt, 16'd5);
        cnt = 0;
        while (!cpu_done && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) cpu_req = 1'b0;
        end
        chk("prio accept timing", cnt, 3);
        chk("prio rdata", cpu_rdata, 32'h777);
        chk("prio hit_cnt", hit_cnt, 16'd6);
        check_txns("prio");
        @(negedge clk);

        // Reset while REFILL waits for ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h123;
        @(negedge clk);
        cpu_req = 1'b0;
        guard = 0;
        while (!mem_req && guard < 20) begin @(negedge clk); guard++; end
        chk("rst refill issued", mem_req, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst mem_req async drop", mem_req, 1'b0);
        chk("rst state idle", dbg_state, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        extra_ack = 1'b1;
        @(negedge clk);
        extra_ack = 1'b0;
        @(negedge clk);
        chk("late ack ready", cpu_ready, 1'b1);
        chk("late ack no done", cpu_done, 1'b0);
        chk("late ack no mem_req", mem_req, 1'b0);
        chk("rst hit_cnt", hit_cnt, 16'h0);
        chk("rst miss_cnt", miss_cnt, 16'h0);
        check_txns("rst");
        do_req(1'b0, 32'h123, 32'h0, lat);
        chk("reread latency", lat, 6);
        chk("reread rdata", cpu_rdata, 32'h1123);
        chk("reread miss_cnt", miss_cnt, 16'd1);
        chk("reread hit_cnt", hit_cnt, 16'd0);
        exp_q.push_back(tx(0, 12'h123, 0));
        check_txns("reread");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global timeout: checks %0d errors %0d", n_checks, n_err);
        $fatal(1);
    end
endmodule
